hazard_scoreboard: RTL and testbench

Register-dependency scoreboard that sequences instruction issue out of decode. Tracks, per architectural register, how many cycles remain until an in-flight producer's result becomes available on the EXE/MEM bypass. It raises `stall` to hold the decode stage on RAW or WAW conflicts. It sits beside `decode_stage`, consumes the decoded register fields, and replaces the decode stage's static hazard flag.

---
 rtl/hazard_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls decode on RAW/WAW hazards against in-flight producers.
// Optional stall-cycle statistic enabled by defining HAZARD_SB_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_FILE_LEN = 32,
    parameter int ALU_LAT      = 1,
    parameter int LOAD_LAT     = 2,
    parameter int MUL_LAT      = 4,
    parameter int CNT_W        = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [$clog2(REG_FILE_LEN)-1:0] src_reg_1,
    input  logic [$clog2(REG_FILE_LEN)-1:0] src_reg_2,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dst_reg,
    input  logic                            uses_src_1,
    input  logic                            uses_src_2,
    input  logic                            writes_rd,
    input  logic [1:0]                      lat_class,
    input  logic                            flush,
    output logic                            stall,
    output logic                            issue_fire,
    output logic [REG_FILE_LEN-1:0]         busy_vec,
    output logic [31:0]                     stall_count
);

    localparam int IDX_W = $clog2(REG_FILE_LEN);

    logic [CNT_W-1:0] counter [REG_FILE_LEN];
    logic [CNT_W-1:0] load_val;
    logic             raw1;
    logic             raw2;
    logic             waw;

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < REG_FILE_LEN; r++) begin
            busy_vec[r] = (counter[r] != '0);
        end
    end

    // x0 never stalls because counter[0] is held at zero, so busy_vec[0] is always clear.
    always_comb begin
        raw1       = uses_src_1 & busy_vec[src_reg_1];
        raw2       = uses_src_2 & busy_vec[src_reg_2];
        waw        = writes_rd & busy_vec[dst_reg];
        stall      = issue_valid & ~flush & (raw1 | raw2 | waw);
        issue_fire = issue_valid & ~stall;
    end

    always_comb begin
        case (lat_class)
            2'd1:    load_val = CNT_W'(LOAD_LAT - 1);
            2'd2:    load_val = CNT_W'(MUL_LAT - 1);
            default: load_val = CNT_W'(ALU_LAT - 1);
        endcase
    end

    // A fresh issue overrides the decrement; WAW stalling guarantees that counter was already zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_FILE_LEN; r++) begin
                counter[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < REG_FILE_LEN; r++) begin
                counter[r] <= '0;
            end
        end else begin
            counter[0] <= '0;
            for (int r = 1; r < REG_FILE_LEN; r++) begin
                if (issue_fire && writes_rd && (dst_reg == IDX_W'(r))) begin
                    counter[r] <= load_val;
                end else if (counter[r] != '0) begin
                    counter[r] <= counter[r] - CNT_W'(1);
                end
            end
        end
    end

`ifdef HAZARD_SB_STATS_EN
    // Saturating count of stalled decode cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (issue_valid && stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal expectations, then random traffic
// checked every cycle against a ready-cycle model. Honours HAZARD_SB_STATS_EN for the stall statistic.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  src_reg_1 = '0;
    logic [4:0]  src_reg_2 = '0;
    logic [4:0]  dst_reg = '0;
    logic        uses_src_1 = 1'b0;
    logic        uses_src_2 = 1'b0;
    logic        writes_rd = 1'b0;
    logic [1:0]  lat_class = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef HAZARD_SB_STATS_EN
    localparam logic [31:0] STATS_ON = 32'd1;
`else
    localparam logic [31:0] STATS_ON = 32'd0;
`endif

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .src_reg_1   (src_reg_1),
        .src_reg_2   (src_reg_2),
        .dst_reg     (dst_reg),
        .uses_src_1  (uses_src_1),
        .uses_src_2  (uses_src_2),
        .writes_rd   (writes_rd),
        .lat_class   (lat_class),
        .flush       (flush),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .busy_vec    (busy_vec),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input int r1, input int r2, input int rd,
                                 input logic u1, input logic u2, input logic wr,
                                 input int cls, input logic fl);
        @(posedge clk);
        #1;
        issue_valid = v;
        src_reg_1   = 5'(r1);
        src_reg_2   = 5'(r2);
        dst_reg     = 5'(rd);
        uses_src_1  = u1;
        uses_src_2  = u2;
        writes_rd   = wr;
        lat_class   = 2'(cls);
        flush       = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Reference model: each register remembers the first cycle at which a consumer may issue.
    longint      ready_at [32];
    longint      cyc = 0;
    logic [31:0] exp_sc = '0;

    function automatic int lat_of(input int cls);
        case (cls)
            1:       return 2;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic is_busy(input int r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
    end

    always @(negedge clk) begin
        logic        e_stall;
        logic        e_fire;
        logic [31:0] e_busy;
        if (!rst) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            exp_sc = '0;
        end
        e_busy = '0;
        for (int r = 0; r < 32; r++) e_busy[r] = is_busy(r);
        e_stall = issue_valid && !flush &&
                  ((uses_src_1 && is_busy(int'(src_reg_1))) ||
                   (uses_src_2 && is_busy(int'(src_reg_2))) ||
                   (writes_rd && is_busy(int'(dst_reg))));
        e_fire = issue_valid && !e_stall;
        checkOutput("stall", 32'(stall), 32'(e_stall));
        checkOutput("issue_fire", 32'(issue_fire), 32'(e_fire));
        checkOutput("busy_vec", busy_vec, e_busy);
        checkOutput("stall_count", stall_count, exp_sc);
        if (rst) begin
            if (e_stall && STATS_ON[0] && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
            if (flush) begin
                for (int r = 0; r < 32; r++) ready_at[r] = 0;
            end else if (e_fire && writes_rd && dst_reg != 0) begin
                ready_at[int'(dst_reg)] = cyc + lat_of(int'(lat_class));
            end
        end
        cyc++;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset, then an independent ALU op
        idle();
        checkOutput("idle_stall", 32'(stall), 0);
        checkOutput("idle_fire", 32'(issue_fire), 0);
        checkOutput("idle_busy", busy_vec, 0);
        checkOutput("idle_stall_count", stall_count, 0);
        applyStimulus(1, 1, 2, 5, 1, 1, 1, 0, 0);
        checkOutput("add_fire", 32'(issue_fire), 1);
        idle();
        checkOutput("add_busy", busy_vec, 0);

        // Load-use: one bubble
        applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 0);
        checkOutput("lw_fire", 32'(issue_fire), 1);
        applyStimulus(1, 5, 1, 6, 1, 1, 1, 0, 0);
        checkOutput("lu_stall", 32'(stall), 1);
        checkOutput("lu_nofire", 32'(issue_fire), 0);
        applyStimulus(1, 5, 1, 6, 1, 1, 1, 0, 0);
        checkOutput("lu_fire", 32'(issue_fire), 1);
        idle();
        checkOutput("lu_stall_count", stall_count, STATS_ON);

        // Multiply feeding both sources: three bubbles
        applyStimulus(1, 1, 2, 7, 1, 1, 1, 2, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 7, 7, 8, 1, 1, 1, 0, 0);
            checkOutput("mul_stall", 32'(stall), 1);
            checkOutput("mul_busy7", 32'(busy_vec[7]), 1);
        end
        applyStimulus(1, 7, 7, 8, 1, 1, 1, 0, 0);
        checkOutput("mul_fire", 32'(issue_fire), 1);
        checkOutput("mul_busy7_clear", 32'(busy_vec[7]), 0);

        // WAW on x9, then a reader sees the ADDI latency
        applyStimulus(1, 1, 2, 9, 1, 1, 1, 2, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 2, 0, 9, 1, 0, 1, 0, 0);
            checkOutput("waw_stall", 32'(stall), 1);
        end
        applyStimulus(1, 2, 0, 9, 1, 0, 1, 0, 0);
        checkOutput("waw_fire", 32'(issue_fire), 1);
        applyStimulus(1, 9, 0, 11, 1, 1, 1, 0, 0);
        checkOutput("waw_reader_fire", 32'(issue_fire), 1);

        // Flush discards in-flight state and the concurrent issue
        applyStimulus(1, 1, 2, 3, 1, 1, 1, 2, 0);
        applyStimulus(1, 3, 0, 10, 1, 0, 1, 2, 1);
        checkOutput("flush_stall", 32'(stall), 0);
        checkOutput("flush_fire", 32'(issue_fire), 1);
        idle();
        checkOutput("flush_busy", busy_vec, 0);
        applyStimulus(1, 10, 0, 12, 1, 0, 1, 0, 0);
        checkOutput("flush_unrecorded", 32'(issue_fire), 1);

        // Asynchronous reset in the middle of a multiply
        applyStimulus(1, 1, 2, 4, 1, 1, 1, 2, 0);
        idle();
        idle();
        checkOutput("pre_reset_busy4", 32'(busy_vec[4]), 1);
        #1 rst = 1'b0;
        #1 checkOutput("async_reset_busy", busy_vec, 0);
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        checkOutput("post_reset_stall_count", stall_count, 0);
        checkOutput("post_reset_busy", busy_vec, 0);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3), ($urandom_range(0, 31) == 0));
        end
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
